// File: rtl/lsu_bus_interface.sv
// Load/store unit bus adapter: turns writeback-stage memory requests into a
// single-outstanding word bus transaction. Define LSU_SUBWORD_ACCESS_EN for byte/half support.
module lsu_bus_interface (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadW,
  input  logic        MemWriteW,
  input  logic [2:0]  Funct3W,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] WD,
  output logic [31:0] ReadData,
  output logic        LsuStall,
  output logic        LsuFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e      state_q, state_d;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        is_load_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        legal, aligned, acc_ok, acc_bad;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [31:0] load_data;

`ifdef LSU_SUBWORD_ACCESS_EN
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] lane;
`else
  logic [2:0]  unused_funct3;
  assign unused_funct3 = Funct3W;
`endif

  // Request decode: lane enables, replicated store data and legality.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    legal     = 1'b1;
    aligned   = (ALUResultW[1:0] == 2'b00);
    acc_be    = 4'b1111;
    acc_wdata = WD;
`ifdef LSU_SUBWORD_ACCESS_EN
    case (Funct3W)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = MemReadW;
      default:                legal = 1'b0;
    endcase
    case (Funct3W[1:0])
      2'b00: begin
        aligned   = 1'b1;
        acc_be    = 4'b0001 << ALUResultW[1:0];
        acc_wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        aligned   = ~ALUResultW[0];
        acc_be    = ALUResultW[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{WD[15:0]}};
      end
      default: ;
    endcase
`endif
    acc_ok  = (MemReadW ^ MemWriteW) & legal & aligned;
    acc_bad = (MemReadW | MemWriteW) & ~acc_ok;
  end

  always_comb begin
`ifdef LSU_SUBWORD_ACCESS_EN
    lane = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{~unsigned_q & lane[7]}}, lane[7:0]};
      2'b01:   load_data = {{16{~unsigned_q & lane[15]}}, lane[15:0]};
      default: load_data = mem_rdata;
    endcase
`else
    load_data = mem_rdata;
`endif
  end

  always_comb begin
    state_d  = state_q;
    LsuStall = 1'b0;
    case (state_q)
      IDLE: if (acc_ok) begin
        state_d  = REQ;
        LsuStall = 1'b1;
      end
      REQ: begin
        LsuStall = 1'b1;
        if (mem_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!reset) LsuStall = 1'b0;
  end

  // NOTE: state uses non-blocking assignments under an async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      is_load_q   <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
`ifdef LSU_SUBWORD_ACCESS_EN
      off_q       <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fault_q <= (state_q == IDLE) & acc_bad;
      if (state_q == IDLE && acc_ok) begin
        mem_we_q    <= MemWriteW;
        mem_addr_q  <= {ALUResultW[31:2], 2'b00};
        mem_wdata_q <= acc_wdata;
        mem_be_q    <= acc_be;
        is_load_q   <= MemReadW;
`ifdef LSU_SUBWORD_ACCESS_EN
        off_q       <= ALUResultW[1:0];
        size_q      <= Funct3W[1:0];
        unsigned_q  <= Funct3W[2];
`endif
      end
      if (state_q == REQ && mem_ack && is_load_q) rdata_q <= load_data;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign ReadData  = rdata_q;
  assign LsuFault  = fault_q;

endmodule

// File: doc/lsu_bus_interface.md
LSU_BUS_INTERFACE -- requirements
Module: lsu_bus_interface

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port MemReadW  in  1  load request from the writeback stage.
REQ-004 SHALL have port MemWriteW  in  1  store request from the writeback stage.
REQ-005 SHALL have port Funct3W  in  3  access size/sign: 000 LB, 001 LH, 010 LW/SW, 100 LBU, 101 LHU; 000/001 also SB/SH.
REQ-006 SHALL have port ALUResultW  in  32  byte address.
REQ-007 SHALL have port WD  in  32  store data, right-aligned.
REQ-008 SHALL have port ReadData  out  32  load result to the datapath.
REQ-009 SHALL have port LsuStall  out  1  pipeline hold request to the hazard unit.
REQ-010 SHALL have port LsuFault  out  1  one-cycle misaligned/illegal-access pulse.
REQ-011 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_wdata out 32, mem_be out 4: bus request.
REQ-012 SHALL have ports mem_ack in 1, mem_rdata in 32: bus response.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DONE.
REQ-014 IDLE: valid request (exactly one of MemReadW/MemWriteW, aligned) -> latch address, size, sign and data; go to REQ; LsuStall=1 combinationally in that cycle.
REQ-015 REQ: mem_req=1; mem_we/mem_addr/mem_wdata/mem_be registered and held stable until mem_ack; LsuStall=1.
REQ-016 REQ with mem_ack=1: for loads register the extracted, extended mem_rdata into ReadData; go to DONE.
REQ-017 DONE: mem_req=0, LsuStall=0 for exactly one cycle so the pipeline advances; inputs ignored; next state IDLE.
REQ-018 Minimum latency, request seen in cycle N with ack in N+1: ReadData valid and LsuStall=0 in N+2 (2 stall cycles); each extra ack-wait cycle adds one.
REQ-019 mem_addr SHALL be {ALUResultW[31:2],2'b00}; mem_be/mem_wdata lanes selected by ALUResultW[1:0].
REQ-020 Load extraction: byte/half selected by address offset; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-021 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or MemReadW&MemWriteW both high: no bus request, LsuFault=1 for one cycle, LsuStall=0, ReadData unchanged, stay IDLE.
REQ-022 ReadData SHALL hold its value until the next completed load; stores never modify it.
REQ-023 mem_ack outside REQ SHALL be ignored.
REQ-024 Unsupported Funct3W encodings SHALL raise LsuFault as in REQ-021.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ReadData=0, LsuFault=0.
REQ-026 LsuStall SHALL be 0 while reset=0.
REQ-027 Reset during REQ SHALL drop mem_req immediately and abort the access; any later ack is ignored.

Configuration
REQ-028 Macro LSU_SUBWORD_ACCESS_EN defined: byte/halfword accesses per REQ-005/019/020.
REQ-029 Macro LSU_SUBWORD_ACCESS_EN undefined: Funct3W ignored, all accesses are words, mem_be=4'b1111, ReadData=mem_rdata, any addr[1:0]!=0 faults.

Verification
REQ-030 LW addr 0x100, ack one cycle after req, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 1111, LsuStall high 2 cycles, then ReadData 0xDEADBEEF.
REQ-031 LB addr 0x103, mem_rdata 0x80FFFFFF -> mem_be 1000, ReadData 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x202, WD 0x0000ABCD, ack delayed 3 cycles -> mem_we 1, mem_be 1100, mem_wdata[31:16]=0xABCD, outputs stable 4 REQ cycles, ReadData unchanged.
REQ-033 LW addr 0x101 -> no mem_req, LsuFault one-cycle pulse, LsuStall 0.
REQ-034 reset=0 mid-REQ, then ack pulse after release -> mem_req 0 immediately, state IDLE, ReadData 0, ack ignored.
REQ-035 Macro undefined, LB addr 0x100 -> mem_be 1111, ReadData = full mem_rdata word.
